// File: rtl/fm_sb_capture_ctrl.sv
// rtl/fm_sb_capture_ctrl.sv - trigger-based spy-buffer capture controller
// Optional trigger timestamp output is enabled by macro FM_SB_CAPTURE_TS_EN.
module fm_sb_capture_ctrl #(
   parameter int DATA_W = 256,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] fm_data,
   input  logic              fm_vld,
   input  logic              arm,
   input  logic              trig,
   input  logic [ADDR_W-1:0] post_cnt,
   output logic              sb_we,
   output logic [ADDR_W-1:0] sb_addr,
   output logic [DATA_W-1:0] sb_wdata,
   output logic [ADDR_W-1:0] meta_trig_addr,
   output logic              meta_wrapped,
`ifdef FM_SB_CAPTURE_TS_EN
   output logic [31:0]       meta_trig_ts,
`endif
   output logic [1:0]        state,
   output logic              frozen
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      POST   = 2'd2,
      FROZEN = 2'd3
   } state_t;

   state_t            st;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] pcnt;

   assign state = st;

`ifdef FM_SB_CAPTURE_TS_EN
   logic [31:0] ts_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         ts_cnt       <= '0;
         meta_trig_ts <= '0;
      end else begin
         ts_cnt <= ts_cnt + 32'd1;
         if (st == ARMED && trig)
            meta_trig_ts <= ts_cnt;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         st             <= IDLE;
         ptr            <= '0;
         pcnt           <= '0;
         sb_we          <= 1'b0;
         sb_addr        <= '0;
         sb_wdata       <= '0;
         meta_trig_addr <= '0;
         meta_wrapped   <= 1'b0;
         frozen         <= 1'b0;
      end else begin
         sb_we <= 1'b0;
         case (st)
            IDLE: begin
               if (arm) begin
                  st           <= ARMED;
                  ptr          <= '0;
                  meta_wrapped <= 1'b0;
               end
            end
            ARMED: begin
               if (fm_vld) begin
                  sb_we    <= 1'b1;
                  sb_addr  <= ptr;
                  sb_wdata <= fm_data;
                  ptr      <= ptr + ADDR_W'(1);
                  if (ptr == {ADDR_W{1'b1}})
                     meta_wrapped <= 1'b1;
               end
               // The trigger-cycle word (if any) is not counted against post_cnt.
               if (trig) begin
                  meta_trig_addr <= ptr;
                  if (post_cnt == '0) begin
                     st     <= FROZEN;
                     frozen <= 1'b1;
                  end else begin
                     st   <= POST;
                     pcnt <= post_cnt;
                  end
               end
            end
            POST: begin
               if (fm_vld) begin
                  sb_we    <= 1'b1;
                  sb_addr  <= ptr;
                  sb_wdata <= fm_data;
                  ptr      <= ptr + ADDR_W'(1);
                  pcnt     <= pcnt - ADDR_W'(1);
                  if (ptr == {ADDR_W{1'b1}})
                     meta_wrapped <= 1'b1;
                  if (pcnt == ADDR_W'(1)) begin
                     st     <= FROZEN;
                     frozen <= 1'b1;
                  end
               end
            end
            FROZEN: begin
               if (arm) begin
                  st           <= ARMED;
                  ptr          <= '0;
                  meta_wrapped <= 1'b0;
                  frozen       <= 1'b0;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fm_sb_capture_ctrl.sv
// tb/tb_fm_sb_capture_ctrl.sv - scoreboard testbench for fm_sb_capture_ctrl
// Build with FM_SB_CAPTURE_TS_EN defined to also exercise the trigger timestamp.
module tb_fm_sb_capture_ctrl;

   localparam int DW = 32;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] fm_data;
   logic          fm_vld;
   logic          arm;
   logic          trig;
   logic [AW-1:0] post_cnt;
   logic          sb_we;
   logic [AW-1:0] sb_addr;
   logic [DW-1:0] sb_wdata;
   logic [AW-1:0] meta_trig_addr;
   logic          meta_wrapped;
   logic [1:0]    state;
   logic          frozen;
`ifdef FM_SB_CAPTURE_TS_EN
   logic [31:0]   meta_trig_ts;
`endif

   int checks   = 0;
   int failures = 0;
   int seq      = 0;
   logic [AW+DW-1:0] exp_q[$];

   always #5 clk = ~clk;

   fm_sb_capture_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .fm_data(fm_data), .fm_vld(fm_vld), .arm(arm),
      .trig(trig), .post_cnt(post_cnt), .sb_we(sb_we), .sb_addr(sb_addr),
      .sb_wdata(sb_wdata), .meta_trig_addr(meta_trig_addr),
      .meta_wrapped(meta_wrapped),
`ifdef FM_SB_CAPTURE_TS_EN
      .meta_trig_ts(meta_trig_ts),
`endif
      .state(state), .frozen(frozen)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: every presented write must match the head of the expected queue.
   always @(negedge clk) begin
      if (sb_we === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write actual_addr=%0h actual_data=%0h required=none",
                     sb_addr, sb_wdata);
         end else begin
            logic [AW+DW-1:0] e;
            e = exp_q.pop_front();
            if ({sb_addr, sb_wdata} !== e) begin
               failures++;
               $display("FAIL write actual_addr=%0h actual_data=%0h required_addr=%0h required_data=%0h",
                        sb_addr, sb_wdata, e[AW+DW-1:DW], e[DW-1:0]);
            end
         end
      end
   end

   // One clock of stimulus; if expw, the word is expected at address ea.
   task automatic step(input logic v, input logic a, input logic t, input logic [AW-1:0] pc,
                       input logic expw, input logic [AW-1:0] ea);
      seq++;
      fm_data  = 32'hD000_0000 + DW'(seq);
      fm_vld   = v;
      arm      = a;
      trig     = t;
      post_cnt = pc;
      if (expw) exp_q.push_back({ea, fm_data});
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_sb_we"}, 32'(sb_we), 32'd0);
      chk({tag, "_sb_addr"}, 32'(sb_addr), 32'd0);
      chk({tag, "_sb_wdata"}, sb_wdata, 32'd0);
      chk({tag, "_state"}, 32'(state), 32'd0);
      chk({tag, "_frozen"}, 32'(frozen), 32'd0);
      chk({tag, "_trig_addr"}, 32'(meta_trig_addr), 32'd0);
      chk({tag, "_wrapped"}, 32'(meta_wrapped), 32'd0);
   endtask

   initial begin
      rst = 1'b1; fm_vld = 1'b0; arm = 1'b0; trig = 1'b0; post_cnt = '0; fm_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst = 1'b0;

      // Basic capture: 5 words, trigger word at 5, 3 post words; post_cnt changes later are ignored.
      step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
      chk("armed_state", 32'(state), 32'd1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, AW'(i));
      step(1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 4'd5);
      chk("a_post_state", 32'(state), 32'd2);
      for (int i = 6; i < 9; i++) step(1'b1, 1'b0, 1'b0, 4'd9, 1'b1, AW'(i));
      chk("a_state", 32'(state), 32'd3);
      chk("a_frozen", 32'(frozen), 32'd1);
      chk("a_trig_addr", 32'(meta_trig_addr), 32'd5);
      chk("a_wrapped", 32'(meta_wrapped), 32'd0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 4'd0);
      chk("a_trig_in_frozen", 32'(state), 32'd3);

      // Wrap: 20 words through a 16-deep buffer, trigger at 4, 2 post words.
      step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
      chk("b_rearm_frozen", 32'(frozen), 32'd0);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, AW'(i % 16));
      chk("b_wrapped_pre", 32'(meta_wrapped), 32'd1);
      step(1'b1, 1'b0, 1'b1, 4'd2, 1'b1, 4'd4);
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5);
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd6);
      chk("b_state", 32'(state), 32'd3);
      chk("b_wrapped", 32'(meta_wrapped), 32'd1);
      chk("b_trig_addr", 32'(meta_trig_addr), 32'd4);
      idle(2);

      // Re-arm clears wrap but holds the trigger address; post_cnt=0 freezes on the trigger.
      step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
      chk("c_wrap_cleared", 32'(meta_wrapped), 32'd0);
      chk("c_trig_addr_held", 32'(meta_trig_addr), 32'd4);
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, AW'(i));
      step(1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 4'd7);
      chk("c_state", 32'(state), 32'd3);
      chk("c_trig_addr", 32'(meta_trig_addr), 32'd7);
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);

      // Gapped post phase: trigger without a word, then 1-in-3 valid, post_cnt=4.
      step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd0);
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd1);
      step(1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 4'd0);
      chk("d_trig_addr", 32'(meta_trig_addr), 32'd2);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, (i == 0), 1'b0, 4'd0, 1'b0, 4'd0);
         step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
         if (i == 3) chk("d_state_before_last", 32'(state), 32'd2);
         step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, AW'(2 + i));
      end
      chk("d_state", 32'(state), 32'd3);
      idle(3);

      // Reset in POST aborts the capture; a later trigger is ignored until arm.
      step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, AW'(i));
      step(1'b1, 1'b0, 1'b1, 4'd5, 1'b1, 4'd3);
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd4);
      rst = 1'b1;
      step(1'b1, 1'b1, 1'b1, 4'd5, 1'b0, 4'd0);
      chk_reset_outputs("rst_post");
      rst = 1'b0;
      step(1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 4'd0);
      chk("e_trig_ignored_state", 32'(state), 32'd0);
      chk("e_trig_ignored_addr", 32'(meta_trig_addr), 32'd0);
      step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd0);
      idle(2);

`ifdef FM_SB_CAPTURE_TS_EN
      rst = 1'b1;
      step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
      chk("ts_reset", meta_trig_ts, 32'd0);
      rst = 1'b0;
      step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
      idle(99);
      step(1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 4'd0);
      chk("ts_trig", meta_trig_ts, 32'd100);
      idle(2);
`endif

      chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fm_sb_capture_ctrl.md
FM_SB_CAPTURE_CTRL -- requirements
Module: fm_sb_capture_ctrl

Interface
REQ-001 SHALL take parameter DATA_W, default 256: width of the monitored fm_data word.
REQ-002 SHALL take parameter ADDR_W, default 10: spy memory address width (depth 2**ADDR_W).
REQ-003 SHALL have port clk  in  1  the single clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port fm_data  in  DATA_W  monitored data word.
REQ-006 SHALL have port fm_vld  in  1  fm_data is valid this cycle.
REQ-007 SHALL have port arm  in  1  single-cycle pulse that starts capture.
REQ-008 SHALL have port trig  in  1  single-cycle trigger pulse.
REQ-009 SHALL have port post_cnt  in  ADDR_W  number of valid words stored after the trigger.
REQ-010 SHALL have port sb_we  out  1  spy memory write enable.
REQ-011 SHALL have port sb_addr  out  ADDR_W  spy memory write address.
REQ-012 SHALL have port sb_wdata  out  DATA_W  spy memory write data.
REQ-013 SHALL have port meta_trig_addr  out  ADDR_W  address written on the trigger cycle.
REQ-014 SHALL have port meta_wrapped  out  1  write pointer has wrapped since arm.
REQ-015 SHALL have port state  out  2  current state encoding.
REQ-016 SHALL have port frozen  out  1  capture complete; memory is stable for readout.

Function
REQ-017 SHALL implement states IDLE=0, ARMED=1, POST=2, FROZEN=3.
REQ-018 IDLE: no writes; arm -> ARMED, write pointer cleared to 0, meta_wrapped cleared.
REQ-019 ARMED: each fm_vld cycle SHALL write fm_data at the pointer, then increment it modulo 2**ADDR_W.
REQ-020 Pointer increment from 2**ADDR_W-1 to 0 SHALL set meta_wrapped, which is sticky until the next arm.
REQ-021 trig in ARMED SHALL latch the current pointer into meta_trig_addr and go to POST, with the post counter loaded from post_cnt.
REQ-022 If trig and fm_vld coincide, the word SHALL be written and its address becomes meta_trig_addr.
REQ-023 POST: each fm_vld write SHALL decrement the post counter; the write that reaches 0 SHALL be the last one, and the block goes to FROZEN on the next cycle.
REQ-024 post_cnt=0 SHALL go directly from ARMED to FROZEN on the trigger cycle, and only the trigger-cycle word (if fm_vld) is written.
REQ-025 FROZEN: no writes, frozen=1; arm -> ARMED (re-arm, pointer and wrap cleared, meta_trig_addr held until the next trigger).
REQ-026 trig outside ARMED SHALL be ignored; arm in ARMED or POST SHALL be ignored.
REQ-027 sb_we/sb_addr/sb_wdata SHALL be registered: a write decided in cycle N is presented in cycle N+1 (1-cycle latency).
REQ-028 post_cnt SHALL be sampled only on the trigger cycle; later changes have no effect.

Reset
REQ-029 rst SHALL force state=IDLE, pointer=0, post counter=0, sb_we=0, sb_addr=0, sb_wdata=0, meta_trig_addr=0, meta_wrapped=0, frozen=0.
REQ-030 rst asserted mid-capture SHALL abort the capture with no further write in the following cycle; rst has priority over arm/trig.

Configuration
REQ-031 Macro FM_SB_CAPTURE_TS_EN SHALL, when defined, add output meta_trig_ts (32 bits, reset 0): a free-running clk counter, cleared by rst, latched on the trigger cycle.
REQ-032 Without FM_SB_CAPTURE_TS_EN, meta_trig_ts and its counter SHALL NOT exist; all other behaviour is identical.

Verification
REQ-033 Reset, then arm, 5 fm_vld words, trig with post_cnt=3 and fm_vld held high -> writes addrs 0..8, meta_trig_addr=5, frozen=1 after addr 8, meta_wrapped=0.
REQ-034 ADDR_W=4: arm, 20 valid words, trig, post_cnt=2 -> addr sequence wraps 15->0, meta_wrapped=1, meta_trig_addr=4, final write at addr 6.
REQ-035 trig with post_cnt=0 and fm_vld=1 at pointer 7 -> single write at 7, state=FROZEN next cycle, no further sb_we.
REQ-036 Gapped fm_vld (1 of 3 cycles) in POST, post_cnt=4 -> exactly 4 post-trigger writes, contiguous addresses.
REQ-037 rst pulse in POST -> sb_we=0 in the cycle after rst, all outputs at reset values, a later trig is ignored until arm.
REQ-038 With FM_SB_CAPTURE_TS_EN: trig 100 cycles after rst release -> meta_trig_ts=100 (±the defined counter offset, checked exactly).
